// File: rtl/data_mem_responder_if.sv
// Data-port bus between the CPU MEM stage (master) and the data memory responder (slave).
// DMEM_ALIGN_CHK_EN adds the misalign completion flag.
interface data_mem_responder_if;
    logic        req_d_valid;
    logic [1:0]  DMC;
    logic [31:0] Daddr;
    logic [31:0] Dwdata;
    logic [31:0] Drdata;
    logic        ready;
    logic        rsp_valid;
`ifdef DMEM_ALIGN_CHK_EN
    logic        misalign;

    modport master (output req_d_valid, DMC, Daddr, Dwdata,
                    input  Drdata, ready, rsp_valid, misalign);
    modport slave  (input  req_d_valid, DMC, Daddr, Dwdata,
                    output Drdata, ready, rsp_valid, misalign);
`else
    modport master (output req_d_valid, DMC, Daddr, Dwdata,
                    input  Drdata, ready, rsp_valid);
    modport slave  (input  req_d_valid, DMC, Daddr, Dwdata,
                    output Drdata, ready, rsp_valid);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM responder with word/byte stores and programmable latency.
// Optional macro DMEM_ALIGN_CHK_EN: flags and suppresses misaligned word accesses.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    data_mem_responder_if.slave  bus
);
    localparam logic [1:0]  OP_NONE = 2'b00;
    localparam logic [1:0]  OP_LW   = 2'b01;
    localparam logic [1:0]  OP_SW   = 2'b10;
    localparam logic [1:0]  OP_SB   = 2'b11;
    localparam logic [31:0] MIS_RD  = 32'hDEAD_BEEF;
    localparam int          DEPTH   = 1 << ADDR_W;

    logic [31:0]       mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [31:0]       mem_wdata;

    logic [ADDR_W-1:0] req_idx;
    logic [1:0]        req_lane;
    logic              req_mis;
    logic              unused_addr;

    assign req_idx     = bus.Daddr[ADDR_W+1:2];
    assign req_lane    = bus.Daddr[1:0];
    assign unused_addr = ^bus.Daddr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHK_EN
    assign req_mis = ((bus.DMC == OP_LW) || (bus.DMC == OP_SW)) && (req_lane != 2'b00);
`else
    assign req_mis = 1'b0;
`endif

    function automatic logic [31:0] merge_store(input logic [31:0] old_w, input logic [1:0] op,
                                                input logic [1:0] lane, input logic [31:0] wd);
        logic [31:0] w;
        w = old_w;
        if (op == OP_SW)
            w = wd;
        else if (op == OP_SB)
            w[8*lane +: 8] = wd[7:0];
        return w;
    endfunction

    // Stores are full-word writes of an already-merged word.
    always_ff @(posedge CLK) begin
        if (mem_we)
            mem_q[mem_widx] <= mem_wdata;
    end

    if (LATENCY == 0) begin : g_comb
        logic acc;

        assign acc        = RESET && bus.req_d_valid && (bus.DMC != OP_NONE);
        assign bus.ready     = 1'b1;
        assign bus.rsp_valid = acc;
        assign bus.Drdata    = (acc && (bus.DMC == OP_LW)) ? (req_mis ? MIS_RD : mem_q[req_idx]) : '0;
        assign mem_we     = acc && bus.DMC[1] && !req_mis;
        assign mem_widx   = req_idx;
        assign mem_wdata  = merge_store(mem_q[req_idx], bus.DMC, req_lane, bus.Dwdata);
`ifdef DMEM_ALIGN_CHK_EN
        assign bus.misalign  = acc && req_mis;
`endif
    end else begin : g_fsm
        typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
        localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);

        state_t            state_q;
        logic [CNT_W-1:0]  cnt_q;
        logic [1:0]        op_q;
        logic [1:0]        lane_q;
        logic [ADDR_W-1:0] idx_q;
        logic [31:0]       wdata_q;
        logic              mis_q;
        logic              ready_q;
        logic              rsp_valid_q;
        logic              misalign_q;
        logic [31:0]       rdata_q;
        logic              acc;
        logic              commit;
        logic [ADDR_W-1:0] rd_idx;
        logic              rd_mis;
        logic [31:0]       rd_word;

        assign acc       = bus.req_d_valid && (bus.DMC != OP_NONE) && ready_q;
        assign commit    = (state_q == S_DONE) && op_q[1] && !mis_q;
        assign mem_we    = commit && RESET;
        assign mem_widx  = idx_q;
        assign mem_wdata = merge_store(mem_q[idx_q], op_q, lane_q, wdata_q);

        // With LATENCY=1 a load accepted in DONE reads while the previous store commits,
        // so the committing word is forwarded.
        always_comb begin
            rd_idx  = (LATENCY == 1) ? req_idx : idx_q;
            rd_mis  = (LATENCY == 1) ? req_mis : mis_q;
            rd_word = mem_q[rd_idx];
            if (commit && (idx_q == rd_idx))
                rd_word = mem_wdata;
            if (rd_mis)
                rd_word = MIS_RD;
        end

        always_ff @(posedge CLK) begin
            if (!RESET) begin
                state_q     <= S_IDLE;
                cnt_q       <= '0;
                ready_q     <= 1'b1;
                rsp_valid_q <= 1'b0;
                misalign_q  <= 1'b0;
                rdata_q     <= '0;
            end else begin
                rsp_valid_q <= 1'b0;
                misalign_q  <= 1'b0;
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (acc) begin
                            op_q    <= bus.DMC;
                            idx_q   <= req_idx;
                            lane_q  <= req_lane;
                            wdata_q <= bus.Dwdata;
                            mis_q   <= req_mis;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                            if (LATENCY == 1) begin
                                state_q     <= S_DONE;
                                ready_q     <= 1'b1;
                                rsp_valid_q <= 1'b1;
                                misalign_q  <= req_mis;
                                if (bus.DMC == OP_LW)
                                    rdata_q <= rd_word;
                            end else begin
                                state_q <= S_BUSY;
                                ready_q <= 1'b0;
                            end
                        end else begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                    S_BUSY: begin
                        if (cnt_q == CNT_W'(1)) begin
                            state_q     <= S_DONE;
                            ready_q     <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            misalign_q  <= mis_q;
                            if (op_q == OP_LW)
                                rdata_q <= rd_word;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end

        assign bus.ready     = ready_q;
        assign bus.rsp_valid = rsp_valid_q;
        assign bus.Drdata    = rdata_q;
`ifdef DMEM_ALIGN_CHK_EN
        assign bus.misalign  = misalign_q;
`else
        logic unused_mis;
        assign unused_mis = misalign_q;
`endif
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder across latency 0/1/2/3/4 and a 4-bit address build.
// Misalign checks are compiled in when DMEM_ALIGN_CHK_EN is defined.
module tb_data_mem_responder;
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] LW   = 2'b01;
    localparam logic [1:0] SW   = 2'b10;
    localparam logic [1:0] SB   = 2'b11;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    data_mem_responder_if ifA ();
    data_mem_responder_if ifB ();
    data_mem_responder_if ifC ();
    data_mem_responder_if ifD ();
    data_mem_responder_if ifE ();

    data_mem_responder #(.ADDR_W(10), .LATENCY(0)) dutA (.CLK(clk), .RESET(rst_n), .bus(ifA));
    data_mem_responder #(.ADDR_W(10), .LATENCY(3)) dutB (.CLK(clk), .RESET(rst_n), .bus(ifB));
    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dutC (.CLK(clk), .RESET(rst_n), .bus(ifC));
    data_mem_responder #(.ADDR_W(4),  .LATENCY(4)) dutD (.CLK(clk), .RESET(rst_n), .bus(ifD));
    data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dutE (.CLK(clk), .RESET(rst_n), .bus(ifE));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int u, input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d);
        case (u)
            0: begin ifA.req_d_valid = v; ifA.DMC = op; ifA.Daddr = a; ifA.Dwdata = d; end
            1: begin ifB.req_d_valid = v; ifB.DMC = op; ifB.Daddr = a; ifB.Dwdata = d; end
            2: begin ifC.req_d_valid = v; ifC.DMC = op; ifC.Daddr = a; ifC.Dwdata = d; end
            3: begin ifD.req_d_valid = v; ifD.DMC = op; ifD.Daddr = a; ifD.Dwdata = d; end
            default: begin ifE.req_d_valid = v; ifE.DMC = op; ifE.Daddr = a; ifE.Dwdata = d; end
        endcase
    endtask

    task automatic idle(input int u);
        drv(u, 1'b0, NONE, 32'h0, 32'h0);
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        n_chk  = 0;
        n_fail = 0;
        for (int u = 0; u < 5; u++) idle(u);

        nxt(); nxt(); #2;
        chk("rst_B_ready", ifB.ready, 1);
        chk("rst_B_rsp", ifB.rsp_valid, 0);
        chk("rst_B_rdata", ifB.Drdata, 0);
        chk("rst_D_ready", ifD.ready, 1);
        chk("rst_D_rsp", ifD.rsp_valid, 0);
        chk("rst_E_ready", ifE.ready, 1);
        chk("rst_A_rsp", ifA.rsp_valid, 0);
        chk("rst_A_rdata", ifA.Drdata, 0);
        rst_n = 1'b1;

        // LATENCY=0
        nxt(); drv(0, 1, SW, 32'h40, 32'h1234_5678); #2;
        chk("A_sw_rsp", ifA.rsp_valid, 1);
        chk("A_sw_ready", ifA.ready, 1);
        chk("A_sw_rdata", ifA.Drdata, 0);
        nxt(); drv(0, 1, LW, 32'h40, 32'h0); #2;
        chk("A_lw_rdata", ifA.Drdata, 32'h1234_5678);
        chk("A_lw_rsp", ifA.rsp_valid, 1);
        nxt(); drv(0, 1, SB, 32'h41, 32'hFFFF_FFAB); #2;
        chk("A_sb_rsp", ifA.rsp_valid, 1);
        nxt(); drv(0, 1, LW, 32'h40, 32'h0); #2;
        chk("A_lw_after_sb", ifA.Drdata, 32'h1234_AB78);
        nxt(); drv(0, 1, LW, 32'h1040, 32'h0); #2;
        chk("A_lw_alias", ifA.Drdata, 32'h1234_AB78);
        nxt(); drv(0, 1, NONE, 32'h40, 32'h0); #2;
        chk("A_none_rsp", ifA.rsp_valid, 0);
        chk("A_none_rdata", ifA.Drdata, 0);
        nxt(); drv(0, 0, LW, 32'h40, 32'h0); #2;
        chk("A_novalid_rsp", ifA.rsp_valid, 0);
        chk("A_novalid_rdata", ifA.Drdata, 0);
`ifdef DMEM_ALIGN_CHK_EN
        nxt(); drv(0, 1, LW, 32'h42, 32'h0); #2;
        chk("A_mis_flag", ifA.misalign, 1);
        chk("A_mis_rdata", ifA.Drdata, 32'hDEAD_BEEF);
        chk("A_mis_rsp", ifA.rsp_valid, 1);
        nxt(); drv(0, 1, SW, 32'h41, 32'h0); #2;
        chk("A_mis_sw_flag", ifA.misalign, 1);
        nxt(); drv(0, 1, LW, 32'h40, 32'h0); #2;
        chk("A_mis_sw_dropped", ifA.Drdata, 32'h1234_AB78);
        chk("A_aligned_flag", ifA.misalign, 0);
`else
        nxt(); drv(0, 1, LW, 32'h42, 32'h0); #2;
        chk("A_lw_trunc", ifA.Drdata, 32'h1234_AB78);
`endif
        nxt(); idle(0);

        // LATENCY=3: store, then load with ignored request during BUSY
        drv(1, 1, SW, 32'h10, 32'hA5A5_0003); #2;
        chk("B_acc_ready", ifB.ready, 1);
        nxt(); drv(1, 1, SW, 32'h10, 32'hFFFF_FFFF); #2;
        chk("B_t1_ready", ifB.ready, 0);
        chk("B_t1_rsp", ifB.rsp_valid, 0);
        nxt(); #2;
        chk("B_t2_ready", ifB.ready, 0);
        chk("B_t2_rsp", ifB.rsp_valid, 0);
        nxt(); idle(1); #2;
        chk("B_t3_rsp", ifB.rsp_valid, 1);
        chk("B_t3_ready", ifB.ready, 1);
        nxt(); drv(1, 1, LW, 32'h10, 32'h0); #2;
        chk("B_t4_rsp", ifB.rsp_valid, 0);
        nxt(); idle(1); #2;
        chk("B_u1_ready", ifB.ready, 0);
        chk("B_u1_rsp", ifB.rsp_valid, 0);
        nxt(); #2;
        chk("B_u2_ready", ifB.ready, 0);
        chk("B_u2_rsp", ifB.rsp_valid, 0);
        nxt(); #2;
        chk("B_u3_rsp", ifB.rsp_valid, 1);
        chk("B_u3_rdata", ifB.Drdata, 32'hA5A5_0003);
        chk("B_u3_ready", ifB.ready, 1);
        nxt(); #2;
        chk("B_u4_rsp", ifB.rsp_valid, 0);
        chk("B_u4_hold", ifB.Drdata, 32'hA5A5_0003);
`ifdef DMEM_ALIGN_CHK_EN
        nxt(); drv(1, 1, LW, 32'h12, 32'h0);
        nxt(); idle(1);
        nxt(); #2;
        chk("B_mis_early", ifB.misalign, 0);
        nxt(); #2;
        chk("B_mis_flag", ifB.misalign, 1);
        chk("B_mis_rdata", ifB.Drdata, 32'hDEAD_BEEF);
        chk("B_mis_rsp", ifB.rsp_valid, 1);
        nxt(); #2;
        chk("B_mis_clear", ifB.misalign, 0);
`endif

        // LATENCY=2: load accepted in the store's DONE cycle
        nxt(); drv(2, 1, SW, 32'h8, 32'h0000_CAFE);
        nxt(); idle(2); #2;
        chk("C_t1_ready", ifC.ready, 0);
        chk("C_t1_rsp", ifC.rsp_valid, 0);
        nxt(); drv(2, 1, LW, 32'h8, 32'h0); #2;
        chk("C_t2_rsp", ifC.rsp_valid, 1);
        chk("C_t2_ready", ifC.ready, 1);
        nxt(); idle(2); #2;
        chk("C_t3_ready", ifC.ready, 0);
        chk("C_t3_rsp", ifC.rsp_valid, 0);
        nxt(); #2;
        chk("C_t4_rsp", ifC.rsp_valid, 1);
        chk("C_bypass", ifC.Drdata, 32'h0000_CAFE);
        nxt(); #2;
        chk("C_t5_rsp", ifC.rsp_valid, 0);

        // LATENCY=1: back-to-back with forwarding of the committing store
        nxt(); drv(4, 1, SW, 32'h20, 32'h0);
        nxt(); #2;
        chk("E_t1_rsp", ifE.rsp_valid, 1);
        drv(4, 1, SW, 32'h20, 32'h1122_3344);
        nxt(); #2;
        chk("E_t2_rsp", ifE.rsp_valid, 1);
        drv(4, 1, LW, 32'h20, 32'h0);
        nxt(); #2;
        chk("E_t3_rsp", ifE.rsp_valid, 1);
        chk("E_fwd_word", ifE.Drdata, 32'h1122_3344);
        drv(4, 1, SB, 32'h21, 32'h0000_00EE);
        nxt(); #2;
        chk("E_t4_rsp", ifE.rsp_valid, 1);
        drv(4, 1, LW, 32'h20, 32'h0);
        nxt(); idle(4); #2;
        chk("E_fwd_byte", ifE.Drdata, 32'h1122_EE44);
        chk("E_t5_rsp", ifE.rsp_valid, 1);
        nxt(); #2;
        chk("E_t6_rsp", ifE.rsp_valid, 0);
        chk("E_t6_ready", ifE.ready, 1);

        // LATENCY=4, ADDR_W=4: address wrap
        nxt(); drv(3, 1, SW, 32'h40, 32'h55);
        nxt(); idle(3); #2;
        chk("D_t1_ready", ifD.ready, 0);
        nxt(); nxt(); #2;
        chk("D_t3_ready", ifD.ready, 0);
        chk("D_t3_rsp", ifD.rsp_valid, 0);
        nxt(); #2;
        chk("D_t4_rsp", ifD.rsp_valid, 1);
        nxt(); drv(3, 1, LW, 32'h0, 32'h0);
        nxt(); idle(3);
        nxt(); nxt(); nxt(); #2;
        chk("D_wrap_rsp", ifD.rsp_valid, 1);
        chk("D_wrap_rdata", ifD.Drdata, 32'h55);

        // Reset while a store is in BUSY
        nxt(); drv(3, 1, SW, 32'h0, 32'h77);
        nxt(); idle(3); #2;
        chk("D_s1_ready", ifD.ready, 0);
        nxt(); rst_n = 1'b0;
        nxt(); rst_n = 1'b1; #2;
        chk("D_rst_ready", ifD.ready, 1);
        chk("D_rst_rsp", ifD.rsp_valid, 0);
        chk("D_rst_rdata", ifD.Drdata, 0);
        nxt(); #2;
        chk("D_s4_rsp", ifD.rsp_valid, 0);
        nxt(); #2;
        chk("D_s5_rsp", ifD.rsp_valid, 0);
        nxt(); drv(3, 1, LW, 32'h0, 32'h0);
        nxt(); idle(3);
        nxt(); nxt(); nxt(); #2;
        chk("D_dropped_rsp", ifD.rsp_valid, 1);
        chk("D_dropped_rdata", ifD.Drdata, 32'h55);

        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
